// File: rtl/log_quantizer_stage.sv
// log_quantizer_stage: 2-stage valid/ready pipeline mapping a magnitude and its leading-one
// position to a {exponent, mantissa} log code. Define LOGQ_ROUND_EN for round-to-nearest-even.
module log_quantizer_stage #(
  parameter int MANT_BITS = 4,
  localparam int CODE_W = 6 + MANT_BITS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              inValid,
  output logic              inReady,
  input  logic [31:0]       inWord,
  input  logic [5:0]        locationOfOne,
  output logic              outValid,
  input  logic              outReady,
  output logic [CODE_W-1:0] outCode,
  output logic [15:0]       satCount
);

  logic                 s1Valid;
  logic [31:0]          s1Word;
  logic [5:0]           s1Loc;
  logic                 adv1;
  logic                 adv2;
  logic [31:0]          n;
  logic [MANT_BITS-1:0] mant;
  logic                 roundUp;
  logic [MANT_BITS:0]   mantSum;
  logic [5:0]           expNext;
  logic [MANT_BITS-1:0] mantNext;
  logic                 satNext;
  logic [CODE_W-1:0]    codeNext;
  logic                 unusedBits;

  assign adv2    = !outValid || outReady;
  assign adv1    = !s1Valid || adv2;
  assign inReady = adv1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1Valid <= 1'b0;
      s1Word  <= 32'd0;
      s1Loc   <= 6'd0;
    end else if (adv1) begin
      s1Valid <= inValid;
      if (inValid) begin
        s1Word <= inWord;
        s1Loc  <= locationOfOne;
      end
    end
  end

  // Normalise so the leading one lands on bit 31; the mantissa is what follows it.
  assign n    = s1Word << (6'd32 - s1Loc);
  assign mant = n[30 -: MANT_BITS];

`ifdef LOGQ_ROUND_EN
  logic guardBit;
  logic stickyBit;
  assign guardBit   = n[30-MANT_BITS];
  assign stickyBit  = |n[29-MANT_BITS:0];
  assign roundUp    = guardBit & (stickyBit | mant[0]);
  assign unusedBits = n[31];
`else
  assign roundUp    = 1'b0;
  assign unusedBits = ^{n[31], n[30-MANT_BITS:0]};
`endif

  // A rounding carry out of the mantissa bumps the exponent; at L=32 it pins to the max code.
  always_comb begin
    mantSum  = {1'b0, mant} + {{MANT_BITS{1'b0}}, roundUp};
    expNext  = s1Loc;
    mantNext = mantSum[MANT_BITS-1:0];
    satNext  = 1'b0;
    if (s1Loc == 6'd0) begin
      expNext  = 6'd0;
      mantNext = '0;
    end else if (mantSum[MANT_BITS]) begin
      if (s1Loc == 6'd32) begin
        expNext  = 6'd32;
        mantNext = '1;
        satNext  = 1'b1;
      end else begin
        expNext = s1Loc + 6'd1;
      end
    end
    codeNext = {expNext, mantNext};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outValid <= 1'b0;
      outCode  <= '0;
      satCount <= 16'd0;
    end else if (adv2) begin
      outValid <= s1Valid;
      if (s1Valid) begin
        outCode <= codeNext;
        if (satNext && (satCount != 16'hFFFF)) begin
          satCount <= satCount + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_log_quantizer_stage.sv
// tb_log_quantizer_stage: scoreboard bench for log_quantizer_stage (MANT_BITS=4), covering
// directed codes, saturation, backpressure, random traffic and mid-stream reset.
module tb_log_quantizer_stage;

  localparam int MB = 4;

  logic          clk;
  logic          rst_n;
  logic          inValid;
  logic          inReady;
  logic [31:0]   inWord;
  logic [5:0]    locationOfOne;
  logic          outValid;
  logic          outReady;
  logic [MB+5:0] outCode;
  logic [15:0]   satCount;

  int            checks;
  int            errors;
  int            expSat;
  logic [31:0]   expQ[$];
  logic [31:0]   drvExp;
  bit            drvSat;
  bit            randDone;

`ifdef LOGQ_ROUND_EN
  localparam logic [31:0] EXP_B6  = 32'h087;
  localparam logic [31:0] EXP_1F8 = 32'h0A0;
`else
  localparam logic [31:0] EXP_B6  = 32'h086;
  localparam logic [31:0] EXP_1F8 = 32'h09F;
`endif

  log_quantizer_stage #(.MANT_BITS(MB)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .inValid      (inValid),
    .inReady      (inReady),
    .inWord       (inWord),
    .locationOfOne(locationOfOne),
    .outValid     (outValid),
    .outReady     (outReady),
    .outCode      (outCode),
    .satCount     (satCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Reference model: scaled integer division with explicit remainder, independent of bit slicing.
  function automatic logic [31:0] modelCode(input logic [31:0] word, input logic [5:0] loc, output bit sat);
    longint unsigned scaled;
    longint unsigned q;
    int l;
    int e;
    bit up;
    sat = 1'b0;
    up  = 1'b0;
    l   = int'(loc);
    if (l == 0) return 32'd0;
    scaled = {32'd0, word} << MB;
    q      = scaled >> (l - 1);
`ifdef LOGQ_ROUND_EN
    begin
      longint unsigned r;
      longint unsigned half;
      r = scaled - (q << (l - 1));
      if (l >= 2) begin
        half = 64'd1 << (l - 2);
        up   = (r > half) || ((r == half) && q[0]);
      end
    end
`endif
    q = q + 64'(up);
    e = l;
    if (q == (64'd1 << (MB + 1))) begin
      q = 64'd1 << MB;
      e = l + 1;
    end
    if (e > 32) begin
      sat = 1'b1;
      return 32'((32 << MB) | ((1 << MB) - 1));
    end
    return 32'((e << MB) | int'(q - (64'd1 << MB)));
  endfunction

  function automatic logic [5:0] locOf(input logic [31:0] w);
    locOf = 6'd0;
    for (int i = 0; i < 32; i++) if (w[i]) locOf = 6'(i + 1);
  endfunction

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic applyStimulus(input logic [31:0] word, input logic [5:0] loc, input logic [31:0] expCode);
    bit sat;
    void'(modelCode(word, loc, sat));
    drvExp        = expCode;
    drvSat        = sat;
    inWord        = word;
    locationOfOne = loc;
    inValid       = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (inReady) begin
        @(posedge clk);
        #1;
        inValid = 1'b0;
        return;
      end
    end
    checkOutput("inReadyTimeout", {31'd0, inReady}, 32'd1);
    inValid = 1'b0;
  endtask

  task automatic applyModel(input logic [31:0] word);
    bit sat;
    logic [5:0] loc;
    loc = locOf(word);
    applyStimulus(word, loc, modelCode(word, loc, sat));
  endtask

  task automatic waitDrain();
    int k;
    k = 0;
    while (((expQ.size() != 0) || outValid) && (k < 200)) begin
      @(negedge clk);
      k++;
    end
    checkOutput("drainQueue", 32'(expQ.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: push on input handshake, pop and compare on output handshake.
  always @(negedge clk) begin
    logic [31:0] expCode;
    if (rst_n) begin
      if (outValid && outReady) begin
        if (expQ.size() == 0) begin
          checkOutput("spuriousOut", {31'd0, outValid}, 32'd0);
        end else begin
          expCode = expQ.pop_front();
          checkOutput("outCode", 32'(outCode), expCode);
        end
      end
      if (inValid && inReady) begin
        expQ.push_back(drvExp);
        if (drvSat) expSat++;
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] w;
    int l;
    checks = 0;
    errors = 0;
    expSat = 0;
    drvExp = 32'd0;
    drvSat = 1'b0;
    randDone = 1'b0;
    rst_n = 1'b0;
    inValid = 1'b0;
    inWord = 32'd0;
    locationOfOne = 6'd0;
    outReady = 1'b1;

    repeat (3) @(negedge clk);
    checkOutput("resetOutValid", {31'd0, outValid}, 32'd0);
    checkOutput("resetOutCode", 32'(outCode), 32'd0);
    checkOutput("resetSatCount", 32'(satCount), 32'd0);
    checkOutput("resetInReady", {31'd0, inReady}, 32'd1);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] directed codes");
    applyStimulus(32'h00000001, 6'd1, 32'h010);
    applyStimulus(32'h00000000, 6'd0, 32'h000);
    applyStimulus(32'h000000B6, 6'd8, EXP_B6);
    applyStimulus(32'h000000B4, 6'd8, 32'h086);
    applyStimulus(32'h000001F8, 6'd9, EXP_1F8);
    waitDrain();
    checkOutput("satAfterDirected", 32'(satCount), 32'(expSat));

    $display("[TB] saturation with held output");
    outReady = 1'b0;
    applyStimulus(32'hFFFFFFFF, 6'd32, 32'h20F);
    repeat (3) @(negedge clk);
    checkOutput("satHeldValid", {31'd0, outValid}, 32'd1);
    checkOutput("satHeldCount", 32'(satCount), 32'(expSat));
    @(posedge clk);
    #1 outReady = 1'b1;
    waitDrain();
    checkOutput("satAfterDrain", 32'(satCount), 32'(expSat));

    $display("[TB] back-to-back stream with backpressure");
    fork
      begin
        applyModel(32'h00000001);
        applyModel(32'h000000B6);
        applyModel(32'h000001F8);
        applyModel(32'h12345678);
        applyModel(32'h00000000);
        applyModel(32'h80000000);
      end
      begin
        repeat (2) @(posedge clk);
        #1 outReady = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("inReadyBackpressure", {31'd0, inReady}, 32'd0);
        repeat (4) @(posedge clk);
        #1 outReady = 1'b1;
      end
    join
    waitDrain();

    $display("[TB] random traffic");
    fork
      begin
        for (int i = 0; i < 24; i++) begin
          l = $urandom_range(0, 32);
          if (l == 0) w = 32'd0;
          else w = 32'((longint'($urandom()) & ((64'd1 << (l - 1)) - 1)) | (64'd1 << (l - 1)));
          applyModel(w);
        end
        randDone = 1'b1;
      end
      begin
        while (!randDone) begin
          @(posedge clk);
          #1 outReady = ($urandom_range(0, 3) != 0);
        end
        outReady = 1'b1;
      end
    join
    waitDrain();
    checkOutput("satAfterRandom", 32'(satCount), 32'(expSat));

    $display("[TB] reset with both stages full");
    outReady = 1'b0;
    applyModel(32'h00000055);
    applyModel(32'h00000003);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("midResetOutValid", {31'd0, outValid}, 32'd0);
    checkOutput("midResetSatCount", 32'(satCount), 32'd0);
    checkOutput("midResetInReady", {31'd0, inReady}, 32'd1);
    expQ.delete();
    expSat = 0;
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1 outReady = 1'b1;
    applyModel(32'h00000009);
    @(negedge clk);
    checkOutput("latencyCycle1", {31'd0, outValid}, 32'd0);
    @(negedge clk);
    checkOutput("latencyCycle2", {31'd0, outValid}, 32'd1);
    waitDrain();
    checkOutput("satAfterReset", 32'(satCount), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
